// File: rtl/boot_pkg.sv
// Shared types and width constants for the power-on image loader.
package boot_pkg;

    localparam int BOOT_DATA_W = 16;
    localparam int BOOT_ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        CSUM,
        DONE,
        FAIL
    } boot_state_t;

endpackage

// File: rtl/boot_wait_counter.sv
// EEPROM access timer: loads ROM_WAIT-1 and counts down; term marks the edge
// on which the EEPROM data is valid.
module boot_wait_counter #(
    parameter int ROM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic term
);

    localparam int CW = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(ROM_WAIT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = en && (cnt_q == '0);

endmodule

// File: rtl/boot_loader.sv
// Copies the boot image from EEPROM into RAM, checks its additive checksum
// and keeps the CPU in reset until the image is verified.
module boot_loader
    import boot_pkg::*;
#(
    parameter int                ADDR_W     = BOOT_ADDR_W,
    parameter int                DATA_W     = BOOT_DATA_W,
    parameter int                BOOT_WORDS = 256,
    parameter int                ROM_WAIT   = 2,
    parameter logic [ADDR_W-1:0] RAM_BASE   = '0
) (
    input  logic              clk,
    input  logic              r,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic              cpu_hold,
    output logic              done,
    output logic              boot_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BOOT_WORDS - 1);
    localparam logic [ADDR_W-1:0] CSUM_ADDR = ADDR_W'(BOOT_WORDS);

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              wc_load, wc_en, wc_term;

    assign wc_en = (state_q == READ) || (state_q == CSUM);

    boot_wait_counter #(
        .ROM_WAIT (ROM_WAIT)
    ) u_wait (
        .clk   (clk),
        .rst_n (r),
        .load  (wc_load),
        .en    (wc_en),
        .term  (wc_term)
    );

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        buf_d   = buf_q;
        wc_load = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = READ;
                wc_load = 1'b1;
            end
            READ: begin
                if (wc_term) begin
                    buf_d   = rom_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A stalled write leaves every register untouched, so the bus holds.
                if (ram_ready) begin
                    sum_d   = sum_q + buf_q;
                    wc_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = CSUM;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = READ;
                    end
                end
            end
            CSUM: begin
                if (wc_term) begin
                    state_d = (rom_data == sum_q) ? DONE : FAIL;
                end
            end
            default: ;
        endcase
    end

    // Outputs depend only on registered state, never directly on an input.
    always_comb begin
        rom_addr  = '0;
        rom_oe    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        boot_err  = 1'b0;
        case (state_q)
            READ: begin
                rom_oe   = 1'b1;
                rom_addr = idx_q;
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = RAM_BASE + idx_q;
                ram_wdata = buf_q;
            end
            CSUM: begin
                rom_oe   = 1'b1;
                rom_addr = CSUM_ADDR;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            FAIL: begin
                boot_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Power-on image loader between the program EEPROM and RAM16B24A.
- After reset release, copies BOOT_WORDS 16-bit words from EEPROM into RAM starting at RAM_BASE.
- Verifies a 16-bit additive checksum and holds the CPU in reset until the image is loaded and verified.
- Feeds RAM directly. Its cpu_hold output gates the CPU reset.

Parameters:
- ADDR_W, 24, address width of both the EEPROM and RAM address buses.
- DATA_W, 16, data word width.
- BOOT_WORDS, 256, number of image words to copy; must be >= 1.
- ROM_WAIT, 2, EEPROM read latency in cycles; must be >= 1.
- RAM_BASE, 0, RAM address that receives image word 0.

Ports:
- clk  in  1  system clock (1 us period).
- r  in  1  reset, asynchronous, active-low.
- rom_addr  out  ADDR_W  EEPROM word address.
- rom_oe  out  1  EEPROM output enable.
- rom_data  in  DATA_W  EEPROM read data; valid ROM_WAIT cycles after rom_oe/rom_addr are presented.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write request.
- ram_ready  in  1  RAM accepts the write on a rising edge where ram_we=1 and ram_ready=1.
- cpu_hold  out  1  1 = keep the CPU in reset.
- done  out  1  image loaded and checksum matched.
- boot_err  out  1  checksum mismatch.

Behaviour:
- Reset (r=0, asynchronous):
  - state=IDLE; idx=0; waitcnt=0; sum=0; buffer=0.
  - Outputs: rom_addr=0, rom_oe=0, ram_addr=0, ram_wdata=0, ram_we=0, cpu_hold=1, done=0, boot_err=0.
- States: IDLE, READ, WRITE, CSUM, DONE, FAIL. All outputs are registered or decoded from state; no combinational path from an input to an output.
- IDLE: first rising edge with r=1 -> READ with waitcnt=0.
- READ:
  - rom_oe=1, rom_addr=idx.
  - waitcnt increments each edge.
  - On the edge where waitcnt==ROM_WAIT-1: buffer<=rom_data, -> WRITE.
- WRITE:
  - ram_we=1, ram_addr=RAM_BASE+idx (mod 2^ADDR_W), ram_wdata=buffer; rom_oe=0.
  - While ram_ready=0: hold every output stable, indefinitely.
  - On the edge with ram_ready=1: sum<=sum+buffer (mod 2^16).
    - If idx==BOOT_WORDS-1: -> CSUM with waitcnt=0.
    - Otherwise: idx<=idx+1, -> READ with waitcnt=0.
- CSUM:
  - rom_oe=1, rom_addr=BOOT_WORDS; wait ROM_WAIT edges as in READ.
  - On the final edge, compare rom_data with sum: equal -> DONE, unequal -> FAIL.
- DONE: cpu_hold=0, done=1; all strobes 0. Terminal until reset.
- FAIL: cpu_hold=1, boot_err=1; all strobes 0. Terminal until reset.
- Latency with ram_ready tied 1: done rises exactly 1 + BOOT_WORDS*(ROM_WAIT+1) + ROM_WAIT edges after reset release.
- ram_we and rom_oe are never 1 in the same cycle.
- Exactly one RAM write is accepted per image word, in ascending address order. The checksum word is never written to RAM.
- Reset mid-operation: aborts immediately to IDLE with all outputs at reset values. The next release restarts from word 0 with sum=0.
- ram_ready has no effect outside WRITE. rom_data is sampled only on the final wait edge.

Decomposition:
- Shared package boot_pkg: state enum boot_state_t (IDLE..FAIL); constants BOOT_DATA_W=16 and BOOT_ADDR_W=24.
- One sub-module, boot_wait_counter: a ROM_WAIT-cycle down-counter with a load input and a terminal pulse. Reused for READ and CSUM.
- The FSM, index register and checksum accumulator stay in boot_loader.

Test Plan (BOOT_WORDS=4, ROM_WAIT=2, RAM_BASE=0x000100 unless stated):
- Nominal load: ROM = 0x0001, 0x0002, 0x0003, 0x0004, checksum 0x000A, ram_ready=1 -> RAM writes (0x000100,0x0001) through (0x000103,0x0004); done=1 and cpu_hold=0 on edge 15 after release.
- Bad checksum: same image with checksum word 0x000B -> four RAM writes, then boot_err=1, cpu_hold=1, done=0, persisting 100 further cycles.
- Wrap-around sum: ROM = 0xFFFF, 0x0002, 0x0000, 0x0000, checksum 0x0001 -> done=1.
- RAM stall: ram_ready=0 for 5 cycles during the write of word 1 -> ram_addr=0x000101 and ram_wdata=0x0002 stable throughout; no duplicate write; done on edge 20.
- Reset mid-load: assert r=0 while in WRITE of word 2 -> outputs return to reset values asynchronously; after release, reload starts at rom_addr=0 and completes with done=1.
- Single word: BOOT_WORDS=1, ROM = 0x1234, checksum 0x1234 -> one write to RAM_BASE, done on edge 6.
